// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, 3-sample majority vote,
// and the oversample tick positions that bracket a bit centre.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_rx_state_t;

   localparam int unsigned SAMPLES_PER_BIT = 3;

   function automatic logic vote3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Sample window is centred on tick os/2; the last sample also decides the bit.
   function automatic int unsigned samp_first(input int unsigned os);
      return os / 2 - 1;
   endfunction

   function automatic int unsigned samp_last(input int unsigned os);
      return samp_first(os) + SAMPLES_PER_BIT - 1;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Clock divider plus per-bit oversample tick counter with sample-window strobes.
// Clear dominates enable; both counters sit at zero while cleared.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV = 325,
   parameter int unsigned OS_RATE = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_en,
   input  logic                       i_clr,
   output logic                       o_tick,
   output logic [$clog2(OS_RATE)-1:0] o_tick_cnt,
   output logic                       o_sample,
   output logic                       o_centre
);
   localparam int unsigned DW = $clog2(CLK_DIV);
   localparam int unsigned TW = $clog2(OS_RATE);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OS_RATE - 1);
   localparam logic [TW-1:0] SAMP_LO   = TW'(samp_first(OS_RATE));
   localparam logic [TW-1:0] SAMP_HI   = TW'(samp_last(OS_RATE));

   logic [DW-1:0] r_div;
   logic [TW-1:0] r_tick_cnt;
   logic          w_tick;

   assign w_tick = i_en && !i_clr && (r_div == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div      <= '0;
         r_tick_cnt <= '0;
      end else if (i_clr) begin
         r_div      <= '0;
         r_tick_cnt <= '0;
      end else if (i_en) begin
         r_div <= w_tick ? '0 : r_div + 1'b1;
         if (w_tick)
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
      end
   end

   assign o_tick     = w_tick;
   assign o_tick_cnt = r_tick_cnt;
   assign o_sample   = w_tick && (r_tick_cnt >= SAMP_LO) && (r_tick_cnt <= SAMP_HI);
   assign o_centre   = w_tick && (r_tick_cnt == SAMP_HI);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-voted bits, ready/valid delivery with error flags.
// Define UART_RX_PARITY_EN to expect and check one parity bit after the data bits.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 325,
   parameter int unsigned OS_RATE    = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic                 frame_err_o,
   output logic                 parity_err_o,
   output logic                 overrun_err_o,
   output logic                 busy_o
);
   localparam int unsigned TW = $clog2(OS_RATE);
   localparam logic [TW-1:0] OS_LAST   = TW'(OS_RATE - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   if (CLK_DIV < 2 || OS_RATE < 8 || OS_RATE > 32 || (OS_RATE % 2) != 0 ||
       DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY_ODD > 1) begin : g_cfg_check
      $error("uart_rx_os: unsupported parameter set");
   end

   logic                 r_sync1, r_sync2, r_prev;
   logic                 w_fall, w_busy;
   uart_rx_state_t       r_state, w_next;
   logic                 w_tick, w_sample, w_centre, w_bit_end;
   logic [TW-1:0]        w_tick_cnt;
   logic                 w_vote, w_done, w_hs, w_load;
   logic [1:0]           r_samp;
   logic [3:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift, r_data;
   logic                 r_ferr, r_valid, r_frame_err, r_ovr;

   // Synchroniser and edge flop reset high so reset release never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= rx_i;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_fall = r_prev & ~r_sync2;
   assign w_busy = (r_state != IDLE);

   uart_baud_tick #(
      .CLK_DIV (CLK_DIV),
      .OS_RATE (OS_RATE)
   ) u_baud (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (w_busy),
      .i_clr      (~w_busy),
      .o_tick     (w_tick),
      .o_tick_cnt (w_tick_cnt),
      .o_sample   (w_sample),
      .o_centre   (w_centre)
   );

   assign w_bit_end = w_tick && (w_tick_cnt == OS_LAST);
   assign w_vote    = vote3(r_samp[1], r_samp[0], r_sync2);
   assign w_done    = (r_state == STOP) && w_centre && (r_bit_cnt == STOP_LAST);
   assign w_hs      = r_valid & rx_ready_i;
   assign w_load    = w_done & (~r_valid | w_hs);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:  if (w_fall) w_next = START;
         START: begin
            if (w_centre && w_vote) w_next = IDLE;
            else if (w_bit_end)     w_next = DATA;
         end
         DATA: begin
            if (w_bit_end && r_bit_cnt == DATA_LAST)
`ifdef UART_RX_PARITY_EN
               w_next = PARITY;
`else
               w_next = STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (w_bit_end) w_next = STOP;
`endif
         // Leave at the last stop-bit centre so a back-to-back start edge is caught.
         STOP:  if (w_done) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_samp    <= '1;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_ferr    <= 1'b0;
      end else begin
         if (w_sample) r_samp <= {r_samp[0], r_sync2};
         if (r_state == IDLE) begin
            r_bit_cnt <= '0;
            r_ferr    <= 1'b0;
         end
         if (w_centre) begin
            case (r_state)
               DATA:    r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
               STOP:    if (!w_vote) r_ferr <= 1'b1;
               default: ;
            endcase
         end
         if (w_bit_end) begin
            if (r_state == DATA)
               r_bit_cnt <= (r_bit_cnt == DATA_LAST) ? '0 : r_bit_cnt + 1'b1;
            else if (r_state == STOP)
               r_bit_cnt <= r_bit_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_ovr       <= 1'b0;
      end else begin
         r_ovr <= 1'b0;
         if (w_load) begin
            r_data      <= r_shift;
            r_valid     <= 1'b1;
            r_frame_err <= r_ferr | ~w_vote;
         end else if (w_done) begin
            r_ovr <= 1'b1;
         end else if (w_hs) begin
            r_valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   localparam logic PAR_SENSE = 1'(PARITY_ODD);

   logic r_perr, r_par_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perr    <= 1'b0;
         r_par_out <= 1'b0;
      end else begin
         if (r_state == IDLE)
            r_perr <= 1'b0;
         else if (r_state == PARITY && w_centre)
            r_perr <= ((^r_shift) ^ w_vote) != PAR_SENSE;
         if (w_load) r_par_out <= r_perr;
      end
   end

   assign parity_err_o = r_par_out;
`else
   assign parity_err_o = 1'b0;
`endif

   assign rx_data_o     = r_data;
   assign rx_valid_o    = r_valid;
   assign frame_err_o   = r_frame_err;
   assign overrun_err_o = r_ovr;
   assign busy_o        = w_busy;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: vector table of frames plus hand-written
// reset, false-start, overrun/backpressure and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_os;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned OS_RATE = 16;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned DATA_BITS = 7;
   localparam int unsigned STOP_BITS = 2;
   localparam bit          PAR_EN    = 1'b1;
`else
   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;
   localparam bit          PAR_EN    = 1'b0;
`endif
   localparam int unsigned BIT_CLKS = CLK_DIV * OS_RATE;
   // Middle sample of a bit lands on the 37th posedge into the bit; flip only around it.
   localparam int unsigned GL_LO = 34;
   localparam int unsigned GL_HI = 38;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 rx_i = 1'b1;
   logic                 rx_ready_i = 1'b1;
   logic [DATA_BITS-1:0] rx_data_o;
   logic                 rx_valid_o, frame_err_o, parity_err_o, overrun_err_o, busy_o;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   uart_rx_os #(
      .CLK_DIV    (CLK_DIV),
      .OS_RATE    (OS_RATE),
      .DATA_BITS  (DATA_BITS),
      .STOP_BITS  (STOP_BITS),
      .PARITY_ODD (0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_i          (rx_i),
      .rx_data_o     (rx_data_o),
      .rx_valid_o    (rx_valid_o),
      .rx_ready_i    (rx_ready_i),
      .frame_err_o   (frame_err_o),
      .parity_err_o  (parity_err_o),
      .overrun_err_o (overrun_err_o),
      .busy_o        (busy_o)
   );

   typedef struct packed {
      logic [8:0] data;
      logic       ferr;
      logic       perr;
   } word_t;

   typedef struct {
      logic [8:0] data;
      logic       par;
      logic       stop;
      int         glitch;
      bit         gap;
      logic [8:0] exp_data;
      logic       exp_ferr;
      logic       exp_perr;
   } vec_t;

   word_t       q[$];
   word_t       mon_w;
   int unsigned n_ovr = 0;
   int unsigned n_valid_cycles = 0;

   always @(negedge clk) begin
      if (rx_valid_o) n_valid_cycles++;
      if (overrun_err_o) n_ovr++;
      if (rx_valid_o && rx_ready_i) begin
         mon_w.data = 9'(rx_data_o);
         mon_w.ferr = frame_err_o;
         mon_w.perr = parity_err_o;
         q.push_back(mon_w);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [8:0] d, input logic par, input logic stop,
                               input int glitch, input bit gap, input logic ferr,
                               input logic perr);
      vec_t v;
      v.data = d; v.par = par; v.stop = stop; v.glitch = glitch; v.gap = gap;
      v.exp_data = d; v.exp_ferr = ferr; v.exp_perr = perr;
      return v;
   endfunction

   task automatic drive_bit(input logic v, input bit glitch);
      for (int c = 0; c < int'(BIT_CLKS); c++) begin
         @(negedge clk);
         rx_i = (glitch && c >= int'(GL_LO) && c < int'(GL_HI)) ? ~v : v;
      end
   endtask

   task automatic send_frame(input logic [8:0] d, input logic par, input logic stop, input int glitch);
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < int'(DATA_BITS); i++) drive_bit(d[i], i == glitch);
      if (PAR_EN) drive_bit(par, 1'b0);
      for (int s = 0; s < int'(STOP_BITS); s++)
         drive_bit((s == int'(STOP_BITS) - 1) ? stop : 1'b1, 1'b0);
   endtask

   task automatic wait_word();
      for (int c = 0; c < 2 * int'(BIT_CLKS) && q.size() == 0; c++) @(negedge clk);
   endtask

   function automatic logic even_par(input logic [8:0] d);
      logic [8:0] m;
      m = d & 9'((1 << DATA_BITS) - 1);
      return ^m;
   endfunction

   vec_t        vecs[$];
   word_t       w;
   int unsigned valid_base;
   int unsigned ovr_base;

   initial begin
`ifdef UART_RX_PARITY_EN
      vecs.push_back(mk(9'h41, 1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(9'h41, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk(9'h7F, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(9'h00, 1'b1, 1'b1, -1, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk(9'h2A, 1'b1, 1'b1,  3, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(9'h55, 1'b0, 1'b0, -1, 1'b1, 1'b1, 1'b0));
`else
      vecs.push_back(mk(9'hA5, 1'b0, 1'b1, -1, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(9'h3C, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(9'hA5, 1'b0, 1'b1,  3, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(9'h55, 1'b0, 1'b0, -1, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(9'h00, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(9'hFF, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0));
`endif

      // Reset and idle
      repeat (3) @(negedge clk);
      check("rst_data",  32'(rx_data_o), 0);
      check("rst_valid", 32'(rx_valid_o), 0);
      check("rst_ferr",  32'(frame_err_o), 0);
      check("rst_perr",  32'(parity_err_o), 0);
      check("rst_ovr",   32'(overrun_err_o), 0);
      check("rst_busy",  32'(busy_o), 0);
      rst_n = 1'b1;
      repeat (10 * BIT_CLKS) @(negedge clk);
      check("idle_no_valid", n_valid_cycles, 0);
      check("idle_busy", 32'(busy_o), 0);

      // False start: quarter-bit low pulse; busy rises 3 clk after the fall
      for (int c = 0; c < int'(BIT_CLKS) / 4; c++) begin
         @(negedge clk);
         if (c == 2) check("start_lat_2clk", 32'(busy_o), 0);
         if (c == 3) check("start_lat_3clk", 32'(busy_o), 1);
         rx_i = 1'b0;
      end
      drive_bit(1'b1, 1'b0);
      drive_bit(1'b1, 1'b0);
      check("false_start_busy", 32'(busy_o), 0);
      check("false_start_noword", n_valid_cycles, 0);

      // Vector table, rx_ready_i high
      valid_base = n_valid_cycles;
      foreach (vecs[i]) begin
         send_frame(vecs[i].data, PAR_EN ? vecs[i].par : 1'b0, vecs[i].stop, vecs[i].glitch);
         wait_word();
         check($sformatf("v%0d_count", i), q.size(), 1);
         if (q.size() > 0) begin
            w = q.pop_front();
            check($sformatf("v%0d_data", i), 32'(w.data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_ferr", i), 32'(w.ferr), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_perr", i), 32'(w.perr), 32'(vecs[i].exp_perr));
         end
         if (vecs[i].gap) drive_bit(1'b1, 1'b0);
      end
      check("valid_pulse_cycles", n_valid_cycles - valid_base, vecs.size());
      check("table_no_overrun", n_ovr, 0);

      // Overrun and backpressure
      @(posedge clk); #2 rx_ready_i = 1'b0;
      ovr_base = n_ovr;
      send_frame(9'h11, even_par(9'h11), 1'b1, -1);
      drive_bit(1'b1, 1'b0);
      check("bp_valid_held", 32'(rx_valid_o), 1);
      check("bp_data_first", 32'(rx_data_o), 32'h11);
      send_frame(9'h22, even_par(9'h22), 1'b1, -1);
      drive_bit(1'b1, 1'b0);
      check("ovr_data_kept", 32'(rx_data_o), 32'h11);
      check("ovr_valid_held", 32'(rx_valid_o), 1);
      check("ovr_pulse_count", n_ovr - ovr_base, 1);
      @(posedge clk); #2 rx_ready_i = 1'b1;
      @(posedge clk); #1;
      check("ready_clears_valid", 32'(rx_valid_o), 0);
      check("bp_handshake_count", q.size(), 1);
      if (q.size() > 0) begin
         w = q.pop_front();
         check("bp_handshake_data", 32'(w.data), 32'h11);
      end

      // Asynchronous reset mid-frame while a word is held
      @(posedge clk); #2 rx_ready_i = 1'b0;
      send_frame(9'h1A, even_par(9'h1A), 1'b1, -1);
      drive_bit(1'b1, 1'b0);
      check("hold_before_rst", 32'(rx_valid_o), 1);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b1, 1'b0);
      drive_bit(1'b0, 1'b0);
      check("busy_mid_frame", 32'(busy_o), 1);
      @(negedge clk); #1;
      rst_n = 1'b0;
      rx_i  = 1'b1;
      #1;
      check("arst_valid", 32'(rx_valid_o), 0);
      check("arst_data", 32'(rx_data_o), 0);
      check("arst_busy", 32'(busy_o), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #2 rx_ready_i = 1'b1;
      valid_base = n_valid_cycles;
      repeat (3 * BIT_CLKS) @(negedge clk);
      check("no_partial_word", n_valid_cycles - valid_base, 0);
      check("post_rst_busy", 32'(busy_o), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
